// File: rtl/block_datapath.sv
// block_datapath: player block position/direction registers and a raster
// pixel scanner that streams the block rectangle to the VGA adapter.
module block_datapath #(
   parameter int         BLK_W = 25,
   parameter int         BLK_H = 10,
   parameter int         X_MAX = 160,
   parameter int         Y_MAX = 120,
   parameter int         X0    = 0,
   parameter int         Y0    = 0,
   parameter int         STEP  = 1,
   parameter logic [2:0] FG    = 3'b111,
   parameter logic [2:0] BG    = 3'b000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       move_en,
   input  logic       load_coord,
   input  logic       datapath_en,
   input  logic       plot,
   input  logic [1:0] op,
   input  logic [1:0] dir,
   input  logic       dir_valid,
   output logic [7:0] x_out,
   output logic [6:0] y_out,
   output logic [2:0] colour,
   output logic       writeEn,
   output logic       pix_done,
   output logic       touch_edge
);

   localparam int PXW = (BLK_W > 1) ? $clog2(BLK_W) : 1;
   localparam int PYW = (BLK_H > 1) ? $clog2(BLK_H) : 1;
   localparam logic [PXW-1:0]   PX_LAST = PXW'(BLK_W - 1);
   localparam logic [PYW-1:0]   PY_LAST = PYW'(BLK_H - 1);
   localparam logic signed [8:0] STEP9  = 9'(STEP);
   localparam logic signed [8:0] BLK_W9 = 9'(BLK_W);
   localparam logic signed [8:0] BLK_H9 = 9'(BLK_H);
   localparam logic signed [8:0] X_MAX9 = 9'(X_MAX);
   localparam logic signed [8:0] Y_MAX9 = 9'(Y_MAX);

   logic [7:0]     cur_x_q, cur_x_d;
   logic [6:0]     cur_y_q, cur_y_d;
   logic [1:0]     dir_q, dir_d;
   logic           first_q, first_d;
   logic [PXW-1:0] px_q, px_d;
   logic [PYW-1:0] py_q, py_d;
   logic [7:0]     x_q, x_d;
   logic [6:0]     y_q, y_d;
   logic [2:0]     colour_q, colour_d;
   logic           we_q, we_d;
   logic           done_q, done_d;
   logic           touch_q, touch_d;

   logic signed [8:0] nx, ny;
   logic              x_clip, y_clip, reversal;

   // Candidate next position one STEP along the current direction, with
   // signed headroom so moves past the left/top bound show up as negative.
   always_comb begin
      nx = $signed({1'b0, cur_x_q});
      ny = $signed({2'b00, cur_y_q});
      case (dir_q)
         2'b00:   nx = nx + STEP9;
         2'b01:   nx = nx - STEP9;
         2'b10:   ny = ny + STEP9;
         default: ny = ny - STEP9;
      endcase
      x_clip   = (nx < 0) || ((nx + BLK_W9) > X_MAX9);
      y_clip   = (ny < 0) || ((ny + BLK_H9) > Y_MAX9);
      // Same axis bit, different sense bit means a direct reversal.
      reversal = (dir[1] == dir_q[1]) && (dir[0] != dir_q[0]);
   end

   // Next-state for direction, position, scan counters and pixel outputs.
   always_comb begin
      cur_x_d  = cur_x_q;
      cur_y_d  = cur_y_q;
      dir_d    = dir_q;
      first_d  = first_q;
      px_d     = px_q;
      py_d     = py_q;
      x_d      = x_q;
      y_d      = y_q;
      colour_d = colour_q;
      we_d     = 1'b0;
      done_d   = 1'b0;
      touch_d  = touch_q;

      if (move_en && dir_valid && !reversal) begin
         dir_d = dir;
      end

      if (load_coord) begin
         if (first_q) begin
            first_d = 1'b0;
         end else begin
            if (x_clip) touch_d = 1'b1;
            else        cur_x_d = nx[7:0];
            if (y_clip) touch_d = 1'b1;
            else        cur_y_d = ny[6:0];
         end
      end

      if (!datapath_en) begin
         // Idle: park the scan at the block origin so every scan starts there.
         px_d = '0;
         py_d = '0;
      end else if (!load_coord) begin
         // A position load in the same cycle freezes the scan for that cycle.
         x_d      = cur_x_q + 8'(px_q);
         y_d      = cur_y_q + 7'(py_q);
         colour_d = (op == 2'b00) ? FG : BG;
         we_d     = plot;
         done_d   = (px_q == PX_LAST) && (py_q == PY_LAST);
         if (px_q == PX_LAST) begin
            px_d = '0;
            py_d = (py_q == PY_LAST) ? '0 : py_q + 1'b1;
         end else begin
            px_d = px_q + 1'b1;
         end
      end
   end

   // State registers; reset drops any scan or move in progress.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cur_x_q  <= 8'(X0);
         cur_y_q  <= 7'(Y0);
         dir_q    <= 2'b00;
         first_q  <= 1'b1;
         px_q     <= '0;
         py_q     <= '0;
         x_q      <= '0;
         y_q      <= '0;
         colour_q <= BG;
         we_q     <= 1'b0;
         done_q   <= 1'b0;
         touch_q  <= 1'b0;
      end else begin
         cur_x_q  <= cur_x_d;
         cur_y_q  <= cur_y_d;
         dir_q    <= dir_d;
         first_q  <= first_d;
         px_q     <= px_d;
         py_q     <= py_d;
         x_q      <= x_d;
         y_q      <= y_d;
         colour_q <= colour_d;
         we_q     <= we_d;
         done_q   <= done_d;
         touch_q  <= touch_d;
      end
   end

   assign x_out      = x_q;
   assign y_out      = y_q;
   assign colour     = colour_q;
   assign writeEn    = we_q;
   assign pix_done   = done_q;
   assign touch_edge = touch_q;

endmodule

// File: tb/tb_block_datapath.sv
// tb_block_datapath: directed scenarios plus randomized traffic, checked
// against a pixel-index based reference model of the block datapath.
module tb_block_datapath;

   localparam int BLK_W = 25;
   localparam int BLK_H = 10;
   localparam int X_MAX = 160;
   localparam int Y_MAX = 120;
   localparam int X0    = 0;
   localparam int Y0    = 0;
   localparam int STEP  = 1;
   localparam int FG    = 7;
   localparam int BG    = 0;
   localparam int TOTAL = BLK_W * BLK_H;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       move_en, load_coord, datapath_en, plot, dir_valid;
   logic [1:0] op, dir;
   logic [7:0] x_out;
   logic [6:0] y_out;
   logic [2:0] colour;
   logic       writeEn, pix_done, touch_edge;

   int checks = 0;
   int errors = 0;

   block_datapath dut (
      .clk(clk), .reset_n(reset_n), .move_en(move_en), .load_coord(load_coord),
      .datapath_en(datapath_en), .plot(plot), .op(op), .dir(dir),
      .dir_valid(dir_valid), .x_out(x_out), .y_out(y_out), .colour(colour),
      .writeEn(writeEn), .pix_done(pix_done), .touch_edge(touch_edge)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks = checks + 1;
      if (act != exp) begin
         errors = errors + 1;
         $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic int opposite(input int d);
      case (d)
         0: return 1;
         1: return 0;
         2: return 3;
         default: return 2;
      endcase
   endfunction

   // Reference model: position as integers, scan as a linear pixel index.
   int mx, my, mdir, idx, ex, ey, ecol;
   bit mfirst, mtouch, ewe, edone;

   always @(posedge clk or negedge reset_n) begin
      int nx, ny;
      if (!reset_n) begin
         mx = X0; my = Y0; mdir = 0; mfirst = 1; mtouch = 0; idx = 0;
         ex = 0; ey = 0; ecol = BG; ewe = 0; edone = 0;
      end else begin
         if (datapath_en && !load_coord) begin
            ex    = mx + idx % BLK_W;
            ey    = my + idx / BLK_W;
            ecol  = (op == 2'b00) ? FG : BG;
            ewe   = plot;
            edone = (idx == TOTAL - 1);
            idx   = (idx + 1) % TOTAL;
         end else begin
            ewe = 0;
            edone = 0;
            if (!datapath_en) idx = 0;
         end
         if (load_coord) begin
            if (mfirst) mfirst = 0;
            else begin
               nx = mx; ny = my;
               case (mdir)
                  0: nx = nx + STEP;
                  1: nx = nx - STEP;
                  2: ny = ny + STEP;
                  default: ny = ny - STEP;
               endcase
               if (nx < 0 || nx + BLK_W > X_MAX) mtouch = 1; else mx = nx;
               if (ny < 0 || ny + BLK_H > Y_MAX) mtouch = 1; else my = ny;
            end
         end
         if (move_en && dir_valid && int'(dir) != opposite(mdir)) mdir = int'(dir);
      end
   end

   // Every-cycle comparison of all outputs against the model.
   always @(posedge clk) begin
      #1;
      check("cyc_x", int'(x_out), ex);
      check("cyc_y", int'(y_out), ey);
      check("cyc_colour", int'(colour), ecol);
      check("cyc_we", int'(writeEn), int'(ewe));
      check("cyc_done", int'(pix_done), int'(edone));
      check("cyc_touch", int'(touch_edge), int'(mtouch));
   end

   int s_fx, s_fy, s_lx, s_ly, s_col, s_we, s_done;
   bit s_done_last;

   task automatic do_load();
      @(negedge clk) load_coord = 1'b1;
      @(negedge clk) load_coord = 1'b0;
   endtask

   task automatic set_dir(input logic [1:0] d);
      @(negedge clk);
      move_en = 1'b1; dir_valid = 1'b1; dir = d;
      @(negedge clk);
      move_en = 1'b0; dir_valid = 1'b0;
   endtask

   task automatic do_scan(input int n, input logic [1:0] o);
      s_we = 0; s_done = 0; s_done_last = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         datapath_en = 1'b1; plot = 1'b1; op = o;
         @(posedge clk);
         #1;
         if (i == 0) begin s_fx = x_out; s_fy = y_out; s_col = colour; end
         if (i == n - 1) begin s_lx = x_out; s_ly = y_out; s_done_last = pix_done; end
         if (writeEn) s_we++;
         if (pix_done) s_done++;
      end
      @(negedge clk);
      datapath_en = 1'b0; plot = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0; move_en = 0; load_coord = 0; datapath_en = 0;
      plot = 0; op = 0; dir = 0; dir_valid = 0;
      repeat (3) @(negedge clk);
      check("rst_we", writeEn, 0);
      check("rst_done", pix_done, 0);
      check("rst_x", x_out, 0);
      check("rst_colour", colour, 0);
      check("rst_touch", touch_edge, 0);
      reset_n = 1'b1;

      // Initial draw at the origin.
      do_load();
      do_scan(250, 2'b00);
      check("t1_first_x", s_fx, 0);  check("t1_first_y", s_fy, 0);
      check("t1_last_x", s_lx, 24);  check("t1_last_y", s_ly, 9);
      check("t1_colour", s_col, 7);  check("t1_we_cnt", s_we, 250);
      check("t1_done_cnt", s_done, 1); check("t1_done_last", s_done_last, 1);

      // Move right, erase.
      set_dir(2'b00);
      do_load();
      do_scan(250, 2'b01);
      check("t2_first_x", s_fx, 1);  check("t2_first_y", s_fy, 0);
      check("t2_last_x", s_lx, 25);  check("t2_last_y", s_ly, 9);
      check("t2_colour", s_col, 0);  check("t2_done_last", s_done_last, 1);

      // Reversal request is ignored; still moving right.
      set_dir(2'b01);
      do_load();
      do_scan(1, 2'b00);
      check("t4_x_after_rev", s_fx, 2);

      // Partial scan then restart from the origin.
      do_scan(40, 2'b00);
      do_scan(250, 2'b00);
      check("t5_restart_x", s_fx, 2);  check("t5_restart_y", s_fy, 0);
      check("t5_done_cnt", s_done, 1); check("t5_done_last", s_done_last, 1);

      // March to the right bound, then clip.
      repeat (133) do_load();
      check("t3_touch_pre", touch_edge, 0);
      do_load();
      check("t3_touch_set", touch_edge, 1);
      do_scan(1, 2'b00);
      check("t3_x_held", s_fx, 135);
      set_dir(2'b10);
      do_load();
      check("t3_touch_sticky", touch_edge, 1);
      do_scan(1, 2'b00);
      check("t3_x_after_down", s_fx, 135);
      check("t3_y_after_down", s_fy, 1);

      // Fresh reset, then randomized traffic including load+scan collisions.
      @(negedge clk) reset_n = 1'b0;
      @(negedge clk) reset_n = 1'b1;
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         move_en     = 1'($urandom_range(1, 0));
         dir_valid   = 1'($urandom_range(1, 0));
         dir         = 2'($urandom_range(3, 0));
         load_coord  = ($urandom_range(15, 0) == 0);
         datapath_en = ($urandom_range(7, 0) != 0);
         plot        = 1'($urandom_range(1, 0));
         op          = 2'($urandom_range(3, 0));
      end
      @(negedge clk);
      move_en = 0; dir_valid = 0; load_coord = 0; datapath_en = 0; plot = 0;

      // Reset in the middle of a scan.
      @(negedge clk);
      datapath_en = 1'b1; plot = 1'b1; op = 2'b00;
      repeat (100) @(posedge clk);
      #3 reset_n = 1'b0;
      #1;
      check("t6_we", writeEn, 0);
      check("t6_done", pix_done, 0);
      check("t6_touch", touch_edge, 0);
      check("t6_x", x_out, 0);
      @(negedge clk);
      datapath_en = 1'b0; plot = 1'b0; reset_n = 1'b1;
      do_load();
      do_scan(1, 2'b00);
      check("t6_pos_x", s_fx, 0);
      check("t6_pos_y", s_fy, 0);

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/block_datapath.md
# block_datapath

Position and pixel-scan datapath directly downstream of the game `FSM`. It consumes the FSM's `move_en`, `load_coord`, `datapath_en`, `plot` and `op` controls, holds the player block's position and direction, and scans the block rectangle one pixel per clock. The resulting `x_out`/`y_out`/`colour`/`writeEn` stream feeds the VGA adapter. It also produces `touch_edge`, which the FSM uses in S_CHECK_OVER.

## Interface

**Parameters**
- `BLK_W`, default 25: block width in pixels.
- `BLK_H`, default 10: block height in pixels. `BLK_W*BLK_H` = 250 matches the FSM done count.
- `X_MAX`, default 160: screen width.
- `Y_MAX`, default 120: screen height.
- `X0`, default 0: start x after reset.
- `Y0`, default 0: start y after reset.
- `STEP`, default 1: pixels moved per `load_coord`.
- `FG`, default 3'b111: draw colour.
- `BG`, default 3'b000: erase colour.

**Ports**
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `move_en` in 1: direction input is accepted while high.
- `load_coord` in 1: one-cycle pulse that commits the next position.
- `datapath_en` in 1: pixel scan advances while high.
- `plot` in 1: pixel write request from the FSM.
- `op` in 2: 00 = draw, 01 = erase, 10/11 = erase.
- `dir` in 2: 00 = right, 01 = left, 10 = down, 11 = up.
- `dir_valid` in 1: `dir` is valid this cycle.
- `x_out` out 8: pixel x.
- `y_out` out 7: pixel y.
- `colour` out 3: pixel colour.
- `writeEn` out 1: VGA write strobe.
- `pix_done` out 1: high with the last pixel of a scan.
- `touch_edge` out 1: sticky flag, set when a move was clipped at a screen bound.

## Operation

**Reset (async, `reset_n`=0)**
- `cur_x`=X0, `cur_y`=Y0, `dir_r`=00, `first`=1.
- `px`=0, `py`=0.
- `x_out`=0, `y_out`=0, `colour`=BG.
- `writeEn`=0, `pix_done`=0, `touch_edge`=0.
- A reset mid-scan or mid-move abandons the scan immediately; there is no partial completion.

**Direction register**
- On `move_en && dir_valid`, `dir_r` <= `dir`.
- Exception: a direct reversal (right<->left, down<->up) is ignored and `dir_r` keeps its value.

**Position update on `load_coord`**
- If `first`=1: clear `first`; position is unchanged. This is the initial load after S_RESET.
- Otherwise move `STEP` in direction `dir_r`, independently per axis:
  - If the new x is < 0 or new x + BLK_W > X_MAX, hold `cur_x` and set `touch_edge`.
  - Apply the same rule for y against Y_MAX.
- Use 9-bit signed intermediates for the compare. The registers stay 8/7 bits.
- `touch_edge` stays high until reset.
- If `load_coord` and `datapath_en` are both high, the position update wins and the scan does not advance that cycle. The FSM never does this; the bench checks it anyway.

**Pixel scan**
- While `datapath_en`=1:
  - `px` increments each cycle.
  - At `px`=BLK_W-1, `px` wraps to 0 and `py` increments.
  - At (BLK_W-1, BLK_H-1), both wrap to 0.
- While `datapath_en`=0, `px` and `py` are forced to 0, so every scan starts at the block origin.
- Registered outputs each cycle `datapath_en`=1:
  - `x_out` <= `cur_x`+`px`; `y_out` <= `cur_y`+`py`.
  - `colour` <= FG if `op`==00, else BG.
  - `writeEn` <= `plot`.
  - `pix_done` <= (`px`==BLK_W-1 && `py`==BLK_H-1).
- While `datapath_en`=0, `writeEn` <= 0 and `pix_done` <= 0. `x_out`/`y_out`/`colour` hold their values.
- Sums never overflow because position is clipped so that `cur_x`+BLK_W <= X_MAX.

## Timing
- Output latency is 1 clock: the inputs (`px`, `py`, `op`, `plot`) sampled at edge N appear on the outputs after edge N+1.
- A full scan is BLK_W*BLK_H = 250 enabled cycles.
- `pix_done` is high for exactly 1 cycle, coincident with the 250th `writeEn`.
- `load_coord` takes effect at the next edge. A scan starting the following cycle uses the new position.
- Draw and erase of the same frame use the same `cur_x`/`cur_y`, because position changes only on `load_coord`.
- `dir_valid` pulses while `move_en`=0 are dropped; there is no queuing.

## Test plan
1. **Initial draw.** Reset, pulse `load_coord`, then `datapath_en`=`plot`=1 with `op`=00 for 250 cycles.
   - Expect 250 `writeEn`, (x,y) from (0,0) to (24,9) in raster order, `colour`=3'b111.
   - Expect `pix_done` only on (24,9).
2. **Move and erase.** Apply `dir`=00 with `dir_valid` and `move_en`, pulse `load_coord`, then scan with `op`=01.
   - Expect the first pixel at (1,0), last at (25,9), `colour`=000.
3. **Right-edge clip.** X0=135, dir right, `load_coord`.
   - Expect `cur_x` stays 135, `touch_edge`=1, and it stays 1 through later moves.
4. **Reversal reject.** With `dir_r`=right, apply `dir`=01.
   - Expect `dir_r` unchanged; the next load moves x by +1.
5. **Scan restart.** Drop `datapath_en` after 40 pixels, then re-raise it.
   - Expect the scan to restart at the block origin and `pix_done` after 250 more enabled cycles.
6. **Reset mid-scan.** Assert `reset_n`=0 at pixel 100.
   - Expect `writeEn`, `pix_done` and `touch_edge` to go to 0 asynchronously and position back to (X0,Y0).
